cordic_fp32: RTL and testbench
==============================

// Module: cordic_fp32
// PURPOSE
// - Pipelined CORDIC cosine unit: takes an IEEE-754 single-precision angle in radians and
//   returns cos(angle) as IEEE-754 single precision.
// - Stages: float->fixed conversion, N_ITER rotation-mode CORDIC stages, fixed->float conversion.
// - Accepts one new operand every clock.
// - Used as the cosine kernel of a custom-instruction datapath.
// - Intermediate fixed-point values are exported for debug.
// PARAMETERS
// - N_ITER  22  number of CORDIC micro-rotation stages (i = 0..N_ITER-1)
// - W       28  fixed-point width, signed Q2.26 (sign, 1 integer bit, 26 fraction bits)
// PORTS
// - clk             in   1   single clock; all registers update on its rising edge
// - rst             in   1   reset, asynchronous, active-low; clears every pipeline register
// - dataa           in   32  angle x, fp32, radians; sampled every cycle
// - result          out  32  cos(x), fp32, registered
// - fixedpoint_in   out  28  registered Q2.26 two's-complement conversion of dataa
// - fixedpoint_out  out  28  registered Q2.26 CORDIC x-output (cos), before float conversion
// BEHAVIOUR
// - Reset: while rst=0, all pipeline registers are 0.
//   - result, fixedpoint_in and fixedpoint_out read 0x0.
//   - Release needs no synchronisation beyond clk.
// - Throughput: 1 operand/cycle. There is no valid or handshake. Every cycle's dataa
//   produces an output.
// - Latency:
//   - fixedpoint_in: 1 cycle after dataa.
//   - fixedpoint_out: N_ITER+1 cycles.
//   - result: N_ITER+2 cycles (24 at defaults).
// - Float->fixed (stage 0):
//   - mag = {1, mant[22:0]} shifted by (exp-127+3).
//   - Left shift when positive, right shift with truncation when negative.
//   - Negate if sign=1.
//   - exp=0 (zero or denormal) -> 0.
//   - Shift ≤ -24 -> 0.
//   - |x| ≥ 2.0, Inf or NaN -> saturate to +/-(2^27-1). result for such inputs is unchecked
//     but must be finite.
// - Supported domain: |x| ≤ 1.0 rad. This is inside the CORDIC convergence range of ~1.74 rad.
// - CORDIC stage i:
//   - d = +1 if z ≥ 0, else -1.
//   - x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*ATAN[i].
//   - Shifts are arithmetic.
//   - All regs are W bits wide; wrap-free for the supported domain.
// - Initial values: x0 = round(K*2^26), K = prod 1/sqrt(1+2^-2i), i < N_ITER (≈0.6072529350);
//   y0 = 0; z0 = fixedpoint_in.
// - ATAN[i] = round(atan(2^-i)*2^26), as a constant table.
// - fixedpoint_out = final x (cos, range [0.54,1.0] in domain).
// - Fixed->float (last stage):
//   - Take sign and magnitude, then find the leading one.
//   - exp = 127 + (pos-26); mantissa = the 23 bits below the leading one, truncated.
//   - Magnitude 0 -> 0x00000000.
// - Accuracy: result within 4 ulp of the exact fp32 cos for |x| ≤ 1.0.
// - cos is even: ±x gives identical result.
// - Reset mid-stream: in-flight operands are discarded. Outputs read 0 until new operands
//   propagate through the full latency.
// TESTING
// - Reset: rst=0 for 2 cycles with dataa toggling -> result=0, fixedpoint_in=0, fixedpoint_out=0.
// - dataa=0xBF060A92 (-0.5236) -> fixedpoint_in=0xDE7D5B8 after 1 cycle;
//   result≈0x3F5DB3D7 (±4 ulp) after 24 cycles.
// - dataa=0x3E860A92 (0.2618) -> fixedpoint_in=0x10C1524; result≈0x3F7746EA (±4 ulp).
// - dataa=0x3F060A92 (+0.5236) -> fixedpoint_in=0x2182A48; result identical to the -0.5236 case.
// - dataa=0x00000000 -> fixedpoint_in=0; fixedpoint_out≈0x4000000; result 0x3F800000 (±4 ulp).
// - Back-to-back: the four operands above on consecutive cycles -> four results on
//   consecutive cycles 24 cycles later, in order, each matching its single-shot value.

Source files
------------

// File: rtl/cordic_fp32.sv
// Pipelined fp32 cosine: fp32 -> Q2.26, N_ITER rotation-mode CORDIC stages, Q2.26 -> fp32.
// Latency N_ITER+2 cycles, one operand accepted every cycle, no handshake and no backpressure.
module cordic_fp32 #(
  parameter int N_ITER = 22,
  parameter int W      = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  dataa,
  output logic [31:0]  result,
  output logic [W-1:0] fixedpoint_in,
  output logic [W-1:0] fixedpoint_out
);
  localparam int FRAC = W - 2;
  localparam int PW   = $clog2(W);
  localparam logic [7:0] EXP_LO  = 8'(127 - (FRAC - 23));
  localparam logic [7:0] EXP_SAT = 8'(127 + (W - 1 - FRAC));
  localparam logic signed [W-1:0] X0 = W'(40752055);  // round(K * 2^26), K over 22 stages

  function automatic logic signed [W-1:0] atan_lut(input int idx);
    logic signed [W-1:0] v;
    case (idx)
      0:  v = W'(52707179);
      1:  v = W'(31114864);
      2:  v = W'(16440240);
      3:  v = W'(8345322);
      4:  v = W'(4188855);
      5:  v = W'(2096470);
      6:  v = W'(1048491);
      7:  v = W'(524277);
      8:  v = W'(262143);
      9:  v = W'(131072);
      10: v = W'(65536);
      11: v = W'(32768);
      12: v = W'(16384);
      13: v = W'(8192);
      14: v = W'(4096);
      15: v = W'(2048);
      16: v = W'(1024);
      17: v = W'(512);
      18: v = W'(256);
      19: v = W'(128);
      20: v = W'(64);
      21: v = W'(32);
      default: v = '0;
    endcase
    return v;
  endfunction

  logic [7:0]   w_exp;
  logic [W-2:0] w_sig;
  logic [W-2:0] w_mag;
  logic [W-1:0] w_fix;

  assign w_exp = dataa[30:23];
  assign w_sig = (W-1)'({1'b1, dataa[22:0]});

  always_comb begin
    w_mag = '0;
    if (w_exp == 8'd0)
      w_mag = '0;
    else if (w_exp >= EXP_SAT)
      w_mag = '1;
    else if (w_exp >= EXP_LO)
      w_mag = w_sig << (w_exp - EXP_LO);
    else
      w_mag = w_sig >> (EXP_LO - w_exp);
  end

  assign w_fix = dataa[31] ? -{1'b0, w_mag} : {1'b0, w_mag};

  logic                r_live;
  logic signed [W-1:0] r_fix;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live <= 1'b0;
      r_fix  <= '0;
    end else begin
      r_live <= 1'b1;
      r_fix  <= w_fix;
    end
  end

  assign fixedpoint_in = r_fix;

  logic signed [W-1:0] w_x [0:N_ITER];
  logic signed [W-1:0] w_y [0:N_ITER-1];
  logic signed [W-1:0] w_z [0:N_ITER-1];

  // x is seeded with 0 until the first post-reset operand, so flushed stages stay at zero.
  assign w_x[0] = r_live ? X0 : '0;
  assign w_y[0] = '0;
  assign w_z[0] = r_fix;

  for (genvar gi = 0; gi < N_ITER; gi++) begin : g_stage
    logic                w_neg;
    logic signed [W-1:0] w_ys;
    logic signed [W-1:0] r_x;

    assign w_neg = w_z[gi][W-1];
    assign w_ys  = w_y[gi] >>> gi;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_x <= '0;
      else      r_x <= w_neg ? w_x[gi] + w_ys : w_x[gi] - w_ys;
    end

    assign w_x[gi+1] = r_x;

    if (gi < N_ITER - 1) begin : g_yz
      logic signed [W-1:0] w_xs;
      logic signed [W-1:0] r_y;
      logic signed [W-1:0] r_z;

      assign w_xs = w_x[gi] >>> gi;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_y <= '0;
          r_z <= '0;
        end else begin
          r_y <= w_neg ? w_y[gi] - w_xs : w_y[gi] + w_xs;
          r_z <= w_neg ? w_z[gi] + atan_lut(gi) : w_z[gi] - atan_lut(gi);
        end
      end

      assign w_y[gi+1] = r_y;
      assign w_z[gi+1] = r_z;
    end
  end

  assign fixedpoint_out = w_x[N_ITER];

  logic          w_osgn;
  logic [W-1:0]  w_omag;
  logic [W-1:0]  w_norm;
  logic [PW-1:0] w_pos;
  logic [22:0]   w_mant;
  logic [7:0]    w_fexp;
  logic [31:0]   r_res;

  assign w_osgn = fixedpoint_out[W-1];
  assign w_omag = w_osgn ? -fixedpoint_out : fixedpoint_out;

  always_comb begin
    w_pos = '0;
    for (int k = 0; k < W; k++)
      if (w_omag[k]) w_pos = PW'(k);
  end

  // Normalise so the leading one sits in the MSB; the mantissa is the truncated bits below it.
  assign w_norm = w_omag << (PW'(W - 1) - w_pos);
  assign w_mant = 23'(w_norm >> (W - 24));
  assign w_fexp = 8'(127 - FRAC) + 8'(w_pos);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              r_res <= '0;
    else if (w_omag == '0) r_res <= '0;
    else                   r_res <= {w_osgn, w_fexp, w_mant};
  end

  assign result = r_res;
endmodule

// File: tb/tb_cordic_fp32.sv
// Directed vector bench for cordic_fp32: single-shot vectors, back-to-back stream, mid-stream reset.
module tb_cordic_fp32;
  localparam int N_ITER = 22;
  localparam int LAT    = N_ITER + 2;
  localparam int NV     = 15;
  localparam logic [31:0] FILLER = 32'h3F800000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dataa;
  logic [31:0] result;
  logic [27:0] fin;
  logic [27:0] fout;

  always #5 clk = ~clk;

  cordic_fp32 #(.N_ITER(N_ITER), .W(28)) dut (
    .clk            (clk),
    .rst            (rst),
    .dataa          (dataa),
    .result         (result),
    .fixedpoint_in  (fin),
    .fixedpoint_out (fout)
  );

  typedef struct {
    logic [31:0] din;
    logic [27:0] fin;
    logic        chk_out;
    logic [27:0] fout;
    logic        chk_res;
    logic [31:0] res;
  } vec_t;

  vec_t vecs [NV];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_tol(input string name, input logic [31:0] act, input logic [31:0] want,
                           input int unsigned tol);
    int unsigned d;
    checks++;
    d = (act > want) ? act - want : want - act;
    if (d > tol) begin
      failures++;
      $display("FAIL %s: got %h, want %h (tol %0d)", name, act, want, tol);
    end
  endtask

  task automatic check_finite(input string name, input logic [31:0] act);
    checks++;
    if (act[30:23] == 8'hFF) begin
      failures++;
      $display("FAIL %s: got %h, want a finite fp32", name, act);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_tol({tag, " result"}, result, 32'h0, 0);
    check_tol({tag, " fixedpoint_in"}, {4'b0, fin}, 32'h0, 0);
    check_tol({tag, " fixedpoint_out"}, {4'b0, fout}, 32'h0, 0);
  endtask

  // Drive one operand for a single cycle, then filler, and check each output at its exact latency.
  task automatic run_single(input int v);
    dataa = vecs[v].din;
    for (int c = 1; c <= LAT; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) begin
        check_tol($sformatf("v%0d fixedpoint_in", v), {4'b0, fin}, {4'b0, vecs[v].fin}, 0);
        dataa = FILLER;
      end
      if (c == N_ITER + 1 && vecs[v].chk_out)
        check_tol($sformatf("v%0d fixedpoint_out", v), {4'b0, fout}, {4'b0, vecs[v].fout}, 64);
      if (c == LAT) begin
        if (vecs[v].chk_res)
          check_tol($sformatf("v%0d result", v), result, vecs[v].res, 4);
        else
          check_finite($sformatf("v%0d result", v), result);
      end
    end
  endtask

  initial begin
    vecs[0]  = '{32'hBF060A92, 28'hDE7D5B8, 1'b1, 28'd58117981, 1'b1, 32'h3F5DB3D7};
    vecs[1]  = '{32'h3E860A92, 28'h10C1524, 1'b1, 28'd64822185, 1'b1, 32'h3F7746EA};
    vecs[2]  = '{32'h3F060A92, 28'h2182A48, 1'b1, 28'd58117981, 1'b1, 32'h3F5DB3D7};
    vecs[3]  = '{32'h00000000, 28'h0000000, 1'b1, 28'd67108864, 1'b1, 32'h3F800000};
    vecs[4]  = '{32'h3F800000, 28'h4000000, 1'b1, 28'd36259074, 1'b0, 32'h0};
    vecs[5]  = '{32'hBF800000, 28'hC000000, 1'b1, 28'd36259074, 1'b0, 32'h0};
    vecs[6]  = '{32'h40000000, 28'h7FFFFFF, 1'b0, 28'h0, 1'b0, 32'h0};
    vecs[7]  = '{32'hC0000000, 28'h8000001, 1'b0, 28'h0, 1'b0, 32'h0};
    vecs[8]  = '{32'h7FC00000, 28'h7FFFFFF, 1'b0, 28'h0, 1'b0, 32'h0};
    vecs[9]  = '{32'hFF800000, 28'h8000001, 1'b0, 28'h0, 1'b0, 32'h0};
    vecs[10] = '{32'h3FFFFFFF, 28'h7FFFFF8, 1'b0, 28'h0, 1'b0, 32'h0};
    vecs[11] = '{32'h33000000, 28'h0000002, 1'b0, 28'h0, 1'b0, 32'h0};
    vecs[12] = '{32'h32800000, 28'h0000001, 1'b0, 28'h0, 1'b0, 32'h0};
    vecs[13] = '{32'h32000000, 28'h0000000, 1'b0, 28'h0, 1'b0, 32'h0};
    vecs[14] = '{32'h00000001, 28'h0000000, 1'b0, 28'h0, 1'b0, 32'h0};

    rst   = 1'b0;
    dataa = 32'h0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1 dataa = $urandom;
    end
    @(negedge clk);
    check_zero_outputs("reset");

    rst   = 1'b1;
    dataa = FILLER;
    repeat (LAT + 1) @(negedge clk);

    for (int v = 0; v < NV; v++) run_single(v);

    // Four operands on consecutive cycles must emerge in order on consecutive cycles.
    dataa = vecs[0].din;
    for (int c = 1; c <= LAT + 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (c == k + 1)
          check_tol($sformatf("b2b%0d fixedpoint_in", k), {4'b0, fin}, {4'b0, vecs[k].fin}, 0);
        if (c == k + LAT)
          check_tol($sformatf("b2b%0d result", k), result, vecs[k].res, 4);
      end
      dataa = (c < 4) ? vecs[c].din : FILLER;
    end

    // Reset with operands in flight: outputs clear at once and stay 0 until new data arrives.
    dataa = vecs[1].din;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero_outputs("midreset async");
    @(negedge clk);
    dataa = $urandom;
    @(negedge clk);
    check_zero_outputs("midreset held");
    rst   = 1'b1;
    dataa = vecs[0].din;
    for (int c = 1; c <= LAT; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1)
        check_tol("post-reset fixedpoint_in", {4'b0, fin}, {4'b0, vecs[0].fin}, 0);
      if (c == N_ITER)
        check_tol("post-reset fixedpoint_out flushed", {4'b0, fout}, 32'h0, 0);
      if (c == N_ITER + 1) begin
        check_tol("post-reset fixedpoint_out", {4'b0, fout}, {4'b0, vecs[0].fout}, 64);
        check_tol("post-reset result flushed", result, 32'h0, 0);
      end
      if (c == LAT)
        check_tol("post-reset result", result, vecs[0].res, 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
